// File: rtl/wb_arbiter_if.sv
// Bundle between the execution units and the write-back arbiter. The units
// present results on this bus, and the arbiter returns grants and the registered write port.
interface wb_arbiter_if #(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
);
    logic [0:NUM_UNITS-1]                   unit_valid;
    logic [0:NUM_UNITS-1][0:4]              unit_addr;
    logic [0:NUM_UNITS-1][0:31]             unit_value;
    logic [0:NUM_UNITS-1][0:RS_ID_WIDTH-1]  unit_rs_id;
    logic [0:NUM_UNITS-1]                   unit_ready;
    logic                                   wb_hold;
    logic                                   write_enable;
    logic [0:4]                             write_addr;
    logic [0:31]                            write_value;
    logic [0:RS_ID_WIDTH-1]                 write_rs_id;

    modport master (
        output unit_valid, unit_addr, unit_value, unit_rs_id, wb_hold,
        input  unit_ready, write_enable, write_addr, write_value, write_rs_id
    );

    modport slave (
        input  unit_valid, unit_addr, unit_value, unit_rs_id, wb_hold,
        output unit_ready, write_enable, write_addr, write_value, write_rs_id
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for the register-file write port. It issues a combinational
// one-hot grant and drives a registered write strobe in the next cycle.
module wb_arbiter #(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [PTR_W:0]   NUM_EXT  = (PTR_W+1)'(NUM_UNITS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_UNITS - 1);

    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_vld;
    logic [PTR_W:0]         cand;
    logic [0:NUM_UNITS-1]   ready;

    logic                   write_enable_q, write_enable_d;
    logic [0:4]             write_addr_q, write_addr_d;
    logic [0:31]            write_value_q, write_value_d;
    logic [0:RS_ID_WIDTH-1] write_rs_id_q, write_rs_id_d;

    // Search from rr_ptr upward with wrap; the first valid unit wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        ready     = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (!grant_vld && bus.unit_valid[cand[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (rst || bus.wb_hold) begin
            grant_vld = 1'b0;
        end
        if (grant_vld) begin
            ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        write_enable_d = grant_vld;
        write_addr_d   = write_addr_q;
        write_value_d  = write_value_q;
        write_rs_id_d  = write_rs_id_q;
        if (grant_vld) begin
            rr_ptr_d      = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            write_addr_d  = bus.unit_addr[grant_idx];
            write_value_d = bus.unit_value[grant_idx];
            write_rs_id_d = bus.unit_rs_id[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_value_q  <= '0;
            write_rs_id_q  <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_value_q  <= write_value_d;
            write_rs_id_q  <= write_rs_id_d;
        end
    end

    assign bus.unit_ready   = ready;
    assign bus.write_enable = write_enable_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.write_value  = write_value_q;
    assign bus.write_rs_id  = write_rs_id_q;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_UNITS, default 4, number of execution units competing for the register file write port (2..8).
REQ-002 Parameter RS_ID_WIDTH, default 5, width of the reservation station ID.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 unit_valid[0:NUM_UNITS-1]  input  1 each  unit i holds a finished result.
REQ-006 unit_addr[0:NUM_UNITS-1]  input  [0:4] each  destination GPR of unit i.
REQ-007 unit_value[0:NUM_UNITS-1]  input  [0:31] each  result value of unit i.
REQ-008 unit_rs_id[0:NUM_UNITS-1]  input  [0:RS_ID_WIDTH-1] each  producing reservation station ID.
REQ-009 unit_ready[0:NUM_UNITS-1]  output  1 each  grant; combinational; transfer occurs when unit_valid[i] and unit_ready[i] are both high.
REQ-010 wb_hold  input  1  when high, no grant is issued this cycle.
REQ-011 write_enable  output  1  registered write strobe to the register file write port.
REQ-012 write_addr  output  [0:4]  registered destination GPR.
REQ-013 write_value  output  [0:31]  registered result value.
REQ-014 write_rs_id  output  [0:RS_ID_WIDTH-1]  registered producing RS ID.

Function
REQ-015 At most one unit_ready bit shall be high in any cycle (one-hot or zero).
REQ-016 unit_ready[i] shall be high only if unit_valid[i] is high, wb_hold is low and rst is low.
REQ-017 Arbitration shall be round-robin: search starts at index rr_ptr, increments, wraps NUM_UNITS-1 -> 0; first valid unit wins.
REQ-018 On a grant to unit g, rr_ptr shall become (g+1) mod NUM_UNITS at the next edge; with no grant rr_ptr shall hold.
REQ-019 Latency: a transfer in cycle t shall produce write_enable=1 in cycle t+1 with write_addr/value/rs_id equal to the granted unit's cycle-t inputs.
REQ-020 With no transfer in cycle t, write_enable shall be 0 in cycle t+1 and write_addr/value/rs_id shall hold their previous values.
REQ-021 write_enable shall never be high for two cycles from one transfer; back-to-back transfers yield consecutive single-cycle strobes.
REQ-022 A unit left valid but not granted shall keep its data; the arbiter stores no request state other than rr_ptr.
REQ-023 Starvation bound: a unit holding unit_valid high with wb_hold low shall be granted within NUM_UNITS cycles.
REQ-024 Dropping unit_valid[i] before a grant is legal; no transfer for i occurs.
REQ-025 The arbiter shall not filter on rs_id; stale-ID rejection is done by the register file.

Reset
REQ-026 While rst is high: unit_ready all 0, rr_ptr <= 0, write_enable <= 0, write_addr/value/rs_id <= 0.
REQ-027 rst asserted during an in-flight strobe shall force write_enable=0 in the next cycle; no transfer occurs during any rst cycle.
REQ-028 First cycle after rst deasserts, unit 0 shall have highest priority.

Verification
REQ-029 Reset: rst high 2 cycles with all unit_valid=1 -> unit_ready=0000, write_enable=0, outputs 0; after release unit 0 granted first.
REQ-030 Single: unit 2 valid, addr=5, value=0xDEADBEEF, rs_id=3 -> unit_ready=0010 in cycle t; write_enable=1, addr=5, value=0xDEADBEEF, rs_id=3 in t+1; write_enable=0 in t+2.
REQ-031 Fairness: all 4 units valid continuously 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3, write_enable high cycles 1..8.
REQ-032 Wrap: rr_ptr=3 (after grant to unit 2), units 0 and 1 valid -> unit 0 granted next, then unit 1.
REQ-033 Hold: wb_hold=1 for 3 cycles with unit 1 valid -> no grant, write_enable=0, rr_ptr unchanged; unit 1 granted the cycle hold drops.
REQ-034 Mid-op reset: grant to unit 3 in cycle t, rst high in t+1 -> write_enable=0 in t+2; unit 0 wins at first post-reset cycle if valid.
